// File: rtl/int_sync_src_pkg.sv
`default_nettype none
// =====================================================================
// Module   : int_sync_src_pkg
// Brief    : Shared constants and helpers for the interrupt source crossing.
// Revision : 1.0
// =====================================================================
package int_sync_src_pkg;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_STRETCH    = 4;
    localparam int DEF_FILTER_LEN = 2;

    // Bits needed to hold any value 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/int_sync_crossing_source_v2_if.sv
`default_nettype none
// =====================================================================
// Module   : int_sync_crossing_source_v2_if
// Brief    : Interrupt lines in, flop-driven crossing lines and busy flags out.
// Revision : 1.0
// =====================================================================
interface int_sync_crossing_source_v2_if
    import int_sync_src_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH
) ();

    logic [NUM_CH-1:0] int_in;
    logic [NUM_CH-1:0] int_mask;
    logic [NUM_CH-1:0] sync_out;
    logic [NUM_CH-1:0] busy;

    modport master (
        output int_in,
        output int_mask,
        input  sync_out,
        input  busy
    );

    modport slave (
        input  int_in,
        input  int_mask,
        output sync_out,
        output busy
    );

endinterface
`default_nettype wire

// File: rtl/int_sync_src_chan.sv
`default_nettype none
// =====================================================================
// Module   : int_sync_src_chan
// Brief    : One interrupt channel: optional filter, level/edge logic, output flop.
// Macro    : INT_SYNC_SRC_FILTER_EN inserts the input stability filter
// Revision : 1.0
// =====================================================================
module int_sync_src_chan
    import int_sync_src_pkg::*;
#(
    parameter logic EDGE       = MODE_LEVEL,
    parameter int   STRETCH    = DEF_STRETCH,
    parameter int   FILTER_LEN = DEF_FILTER_LEN
) (
    input  wire logic clock,
    input  wire logic reset_n,
    input  wire logic i_int,
    input  wire logic i_mask,
    output logic      o_sync,
    output logic      o_busy
);

    logic w_in;

`ifdef INT_SYNC_SRC_FILTER_EN
    localparam int FW = cnt_width(FILTER_LEN);
    localparam logic [FW-1:0] c_filt_last = FW'(FILTER_LEN - 1);

    logic          r_filt;
    logic [FW-1:0] r_fcnt;

    // Count consecutive samples that disagree with the filtered value;
    // any sample that agrees again restarts the run.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_filt <= 1'b0;
            r_fcnt <= '0;
        end else if (i_int == r_filt) begin
            r_fcnt <= '0;
        end else if (r_fcnt == c_filt_last) begin
            r_filt <= i_int;
            r_fcnt <= '0;
        end else begin
            r_fcnt <= r_fcnt + 1'b1;
        end
    end

    assign w_in = r_filt;
`else
    assign w_in = i_int;
`endif

    generate
        if (EDGE == MODE_EDGE) begin : g_edge
            localparam int CW = cnt_width(STRETCH);
            localparam logic [CW-1:0] c_stretch = CW'(STRETCH);

            logic          r_prev;
            logic [CW-1:0] r_cnt;
            logic          r_sync;
            logic          r_busy;
            logic [CW-1:0] w_cnt_nxt;
            logic          w_rise;

            assign w_rise = w_in & ~r_prev;

            // Mask has priority: a cleared mask kills both the stretch and
            // any edge arriving in the same cycle.
            always_comb begin
                w_cnt_nxt = '0;
                if (!i_mask) begin
                    w_cnt_nxt = '0;
                end else if (w_rise) begin
                    w_cnt_nxt = c_stretch;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_prev <= 1'b0;
                    r_cnt  <= '0;
                    r_sync <= 1'b0;
                    r_busy <= 1'b0;
                end else begin
                    r_prev <= w_in;
                    r_cnt  <= w_cnt_nxt;
                    r_sync <= (w_cnt_nxt != '0);
                    r_busy <= (w_cnt_nxt != '0);
                end
            end

            assign o_sync = r_sync;
            assign o_busy = r_busy;
        end else begin : g_level
            logic r_sync;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_sync <= 1'b0;
                end else begin
                    r_sync <= w_in & i_mask;
                end
            end

            assign o_sync = r_sync;
            assign o_busy = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/int_sync_crossing_source_v2.sv
`default_nettype none
// =====================================================================
// Module   : int_sync_crossing_source_v2
// Brief    : Source-side interrupt crossing stage, NUM_CH independent channels.
// Macro    : INT_SYNC_SRC_FILTER_EN enables per-channel input stability filters
// Revision : 1.0
// =====================================================================
module int_sync_crossing_source_v2
    import int_sync_src_pkg::*;
#(
    parameter int              NUM_CH     = DEF_NUM_CH,
    parameter logic [NUM_CH-1:0] EDGE_MASK = '0,
    parameter int              STRETCH    = DEF_STRETCH,
    parameter int              FILTER_LEN = DEF_FILTER_LEN
) (
    input  wire logic                    clock,
    input  wire logic                    reset_n,
    int_sync_crossing_source_v2_if.slave bus
);

    logic [NUM_CH-1:0] w_sync;
    logic [NUM_CH-1:0] w_busy;

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            int_sync_src_chan #(
                .EDGE       (EDGE_MASK[i]),
                .STRETCH    (STRETCH),
                .FILTER_LEN (FILTER_LEN)
            ) u_chan (
                .clock   (clock),
                .reset_n (reset_n),
                .i_int   (bus.int_in[i]),
                .i_mask  (bus.int_mask[i]),
                .o_sync  (w_sync[i]),
                .o_busy  (w_busy[i])
            );
        end
    endgenerate

    assign bus.sync_out = w_sync;
    assign bus.busy     = w_busy;

endmodule
`default_nettype wire
